// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the 32x32 register file.
// Arbitrates the single write port between the ALU and memory-load sources, registers the
// selected write for one cycle, and keeps a per-register busy scoreboard for issue hazards.
// Optional feature: define REGFILE_WB_BYPASS_EN to report write-port forwarding to issue.
module regfile_wb_ctrl #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        wr_en,
  output logic [4:0]  wr_rd,
  output logic [31:0] wr_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rs1_fwd,
  output logic        rs2_fwd
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [4:0]       wr_rd_q, wr_rd_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [31:0]      busy_q, busy_d;

  logic        alu_grant, mem_grant, any_grant;
  logic        alu_starved;
  logic [4:0]  grant_rd;
  logic [31:0] grant_data;
  logic        set_en;

  // Memory normally wins contention; a starved ALU request overrides it.
  always_comb begin
    alu_starved = 32'(starve_cnt_q) >= STARVE_LIMIT;
    alu_grant   = 1'b0;
    mem_grant   = 1'b0;
    if (!RST_X) begin
      if (alu_valid && mem_valid) begin
        alu_grant = alu_starved;
        mem_grant = !alu_starved;
      end else begin
        alu_grant = alu_valid;
        mem_grant = mem_valid;
      end
    end
    any_grant  = alu_grant || mem_grant;
    grant_rd   = alu_grant ? alu_rd : mem_rd;
    grant_data = alu_grant ? alu_data : mem_data;
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  // Starvation counter: count refused ALU cycles (saturating), clear on ALU grant.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (alu_grant) begin
      starve_cnt_d = '0;
    end else if (alu_valid && starve_cnt_q != CntMax) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Output stage next state; address/data hold when nothing is granted.
  always_comb begin
    wr_en_d   = any_grant && (grant_rd != 5'd0);
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    if (any_grant) begin
      wr_rd_d   = grant_rd;
      wr_data_d = grant_data;
    end
  end

  // Issue check and scoreboard next state; a set on the same index overrides the clear.
  always_comb begin
    issue_ready = !RST_X && ((issue_rd == 5'd0) || !busy_q[issue_rd]);
    set_en      = issue_valid && issue_ready && (issue_rd != 5'd0);
    busy_d      = busy_q;
    if (wr_en_q) begin
      busy_d[wr_rd_q] = 1'b0;
    end
    if (set_en) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Source hazard and forwarding outputs.
`ifdef REGFILE_WB_BYPASS_EN
  always_comb begin
    rs1_fwd  = !RST_X && wr_en_q && (wr_rd_q == rs1) && (rs1 != 5'd0);
    rs2_fwd  = !RST_X && wr_en_q && (wr_rd_q == rs2) && (rs2 != 5'd0);
    // A forwarded source is not a hazard unless it is being re-claimed this same cycle.
    rs1_busy = !RST_X && busy_q[rs1] && (rs1 != 5'd0) &&
               !(rs1_fwd && !(set_en && issue_rd == rs1));
    rs2_busy = !RST_X && busy_q[rs2] && (rs2 != 5'd0) &&
               !(rs2_fwd && !(set_en && issue_rd == rs2));
  end
`else
  always_comb begin
    rs1_fwd  = 1'b0;
    rs2_fwd  = 1'b0;
    rs1_busy = !RST_X && busy_q[rs1] && (rs1 != 5'd0);
    rs2_busy = !RST_X && busy_q[rs2] && (rs2 != 5'd0);
  end
`endif

  assign wr_en   = wr_en_q;
  assign wr_rd   = wr_rd_q;
  assign wr_data = wr_data_q;

  // State registers; reset discards any in-flight write and clears the scoreboard.
  always_ff @(posedge CLK or posedge RST_X) begin
    if (RST_X) begin
      starve_cnt_q <= '0;
      wr_en_q      <= 1'b0;
      wr_rd_q      <= 5'd0;
      wr_data_q    <= 32'd0;
      busy_q       <= 32'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_rd_q      <= wr_rd_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl.
module tb_regfile_wb_ctrl;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_rd, mem_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, wr_en, issue_ready;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic        rs1_busy, rs2_busy, rs1_fwd, rs2_fwd;

  int checks = 0;
  int failures = 0;

`ifdef REGFILE_WB_BYPASS_EN
  localparam logic BypassOn = 1'b1;
`else
  localparam logic BypassOn = 1'b0;
`endif

  regfile_wb_ctrl dut (
    .CLK        (CLK),
    .RST_X      (RST_X),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .wr_en      (wr_en),
    .wr_rd      (wr_rd),
    .wr_data    (wr_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rs1_fwd    (rs1_fwd),
    .rs2_fwd    (rs2_fwd)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    alu_rd      = 5'd0;
    alu_data    = 32'd0;
    mem_valid   = 1'b0;
    mem_rd      = 5'd0;
    mem_data    = 32'd0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    rs1         = 5'd0;
    rs2         = 5'd0;
  endtask

  initial begin
    idle_inputs();
    RST_X = 1'b1;

    // Reset held with random inputs: every output stays 0.
    for (int i = 0; i < 4; i++) begin
      alu_valid   = 1'($urandom);
      alu_rd      = 5'($urandom);
      alu_data    = $urandom;
      mem_valid   = 1'($urandom);
      mem_rd      = 5'($urandom);
      mem_data    = $urandom;
      issue_valid = 1'($urandom);
      issue_rd    = 5'($urandom);
      rs1         = 5'($urandom);
      rs2         = 5'($urandom);
      step();
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_rd", 32'(wr_rd), 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_readys", {29'd0, alu_ready, mem_ready, issue_ready}, 32'd0);
      check("rst_rs", {28'd0, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd}, 32'd0);
    end

    // Release, claim rd 5.
    idle_inputs();
    RST_X = 1'b0;
    issue_valid = 1'b1;
    issue_rd = 5'd5;
    rs1 = 5'd5;
    #1;
    check("issue5_ready", 32'(issue_ready), 32'd1);
    check("rs1_5_pre", 32'(rs1_busy), 32'd0);
    step();
    issue_valid = 1'b0;
    #1;
    check("rs1_5_busy", 32'(rs1_busy), 32'd1);
    check("issue5_waw", 32'(issue_ready), 32'd0);

    // Single ALU write.
    alu_valid = 1'b1;
    alu_rd = 5'd7;
    alu_data = 32'hDEADBEEF;
    #1;
    check("alu7_ready", 32'(alu_ready), 32'd1);
    check("alu7_memrdy", 32'(mem_ready), 32'd0);
    step();
    alu_valid = 1'b0;
    check("alu7_wr_en", 32'(wr_en), 32'd1);
    check("alu7_wr_rd", 32'(wr_rd), 32'd7);
    check("alu7_wr_data", wr_data, 32'hDEADBEEF);
    step();
    check("alu7_wr_en_off", 32'(wr_en), 32'd0);
    check("alu7_hold_rd", 32'(wr_rd), 32'd7);
    check("alu7_hold_data", wr_data, 32'hDEADBEEF);

    // Contention: memory wins 4 cycles, ALU on the 5th, memory again on the 6th.
    alu_valid = 1'b1;
    alu_rd = 5'd10;
    alu_data = 32'hA0A0A0A0;
    mem_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_rd = 5'(16 + i);
      mem_data = 32'h1000 + 32'(i);
      #1;
      check($sformatf("starve_alu_rdy%0d", i), 32'(alu_ready), (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("starve_mem_rdy%0d", i), 32'(mem_ready), (i == 4) ? 32'd0 : 32'd1);
      step();
      check($sformatf("starve_wr_rd%0d", i), 32'(wr_rd), (i == 4) ? 32'd10 : 32'(16 + i));
      check($sformatf("starve_wr_data%0d", i), wr_data,
            (i == 4) ? 32'hA0A0A0A0 : 32'h1000 + 32'(i));
    end
    idle_inputs();
    step();

    // WAW then RAW on rd 3.
    issue_valid = 1'b1;
    issue_rd = 5'd3;
    #1;
    check("issue3_ready", 32'(issue_ready), 32'd1);
    step();
    check("issue3_waw", 32'(issue_ready), 32'd0);
    issue_valid = 1'b0;
    mem_valid = 1'b1;
    mem_rd = 5'd3;
    mem_data = 32'h33;
    rs2 = 5'd3;
    #1;
    check("mem3_ready", 32'(mem_ready), 32'd1);
    check("rs2_3_busy_pre", 32'(rs2_busy), 32'd1);
    step();
    mem_valid = 1'b0;
    check("mem3_wr_en", 32'(wr_en), 32'd1);
    check("mem3_wr_rd", 32'(wr_rd), 32'd3);
    check("rs2_3_fwd", 32'(rs2_fwd), 32'(BypassOn));
    check("rs2_3_busy_wb", 32'(rs2_busy), 32'(!BypassOn));
    step();
    check("rs2_3_busy_post", 32'(rs2_busy), 32'd0);
    check("rs2_3_fwd_post", 32'(rs2_fwd), 32'd0);
    check("issue3_free", 32'(issue_ready), 32'd1);
    rs2 = 5'd0;

    // Write to rd 0: accepted, no write, scoreboard untouched.
    alu_valid = 1'b1;
    alu_rd = 5'd0;
    alu_data = 32'h1234;
    rs1 = 5'd5;
    #1;
    check("rd0_ready", 32'(alu_ready), 32'd1);
    step();
    alu_valid = 1'b0;
    check("rd0_wr_en", 32'(wr_en), 32'd0);
    check("rd0_wr_rd", 32'(wr_rd), 32'd0);
    check("rd0_wr_data", wr_data, 32'h1234);
    check("rd0_rs1_5_busy", 32'(rs1_busy), 32'd1);

    // Set/clear collision on rd 9: set wins.
    alu_valid = 1'b1;
    alu_rd = 5'd9;
    alu_data = 32'h99;
    step();
    alu_valid = 1'b0;
    check("col_wr_en", 32'(wr_en), 32'd1);
    check("col_wr_rd", 32'(wr_rd), 32'd9);
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    #1;
    check("col_issue_ready", 32'(issue_ready), 32'd1);
    step();
    issue_valid = 1'b0;
    rs1 = 5'd9;
    #1;
    check("col_busy9", 32'(rs1_busy), 32'd1);
    step();
    check("col_busy9_hold", 32'(rs1_busy), 32'd1);

    // Mid-operation reset drops the in-flight write at once.
    alu_valid = 1'b1;
    alu_rd = 5'd20;
    alu_data = 32'h2020;
    step();
    alu_valid = 1'b0;
    check("mid_wr_en_pre", 32'(wr_en), 32'd1);
    RST_X = 1'b1;
    #1;
    check("mid_wr_en", 32'(wr_en), 32'd0);
    check("mid_wr_data", wr_data, 32'd0);
    check("mid_busy9", 32'(rs1_busy), 32'd0);
    RST_X = 1'b0;
    rs1 = 5'd5;
    #1;
    check("mid_busy5_cleared", 32'(rs1_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
